// File: rtl/i2c_target_regs_if.sv
// Pad-side and local-fabric signal bundle of the I2C target register block.
// The slave modport is the target's view; master is the view of whoever drives the pads and local port.
interface i2c_target_regs_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic              reg_wr_valid;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [7:0]        reg_wr_data;
    logic [ADDR_W-1:0] local_addr;
    logic [7:0]        local_rdata;
    logic              local_we;
    logic [7:0]        local_wdata;
    logic              busy;

    modport slave (
        input  scl_in, sda_in, local_addr, local_we, local_wdata,
        output sda_oe, reg_wr_valid, reg_wr_addr, reg_wr_data, local_rdata, busy
    );

    modport master (
        output scl_in, sda_in, local_addr, local_we, local_wdata,
        input  sda_oe, reg_wr_valid, reg_wr_addr, reg_wr_data, local_rdata, busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a 2^ADDR_W x 8 register file (pointer-then-data protocol) plus a local access port.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 4-sample stability filter on SCL/SDA.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    i2c_target_regs_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_WACK,
        S_WDATA,
        S_RDATA,
        S_RACK,
        S_IGNORE
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_cur, sda_cur;
    logic       scl_prev_q, sda_prev_q;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    // Filtered value is combinational so the extra latency is exactly the 3 history samples.
    always_comb begin
        scl_cur = scl_prev_q;
        sda_cur = sda_prev_q;
        if ((&{scl_sync_q[1], scl_hist_q}) || !(|{scl_sync_q[1], scl_hist_q})) scl_cur = scl_sync_q[1];
        if ((&{sda_sync_q[1], sda_hist_q}) || !(|{sda_sync_q[1], sda_hist_q})) sda_cur = sda_sync_q[1];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end
`else
    assign scl_cur = scl_sync_q[1];
    assign sda_cur = sda_sync_q[1];
`endif

    // Idle-high reset of the conditioning flops avoids a false edge out of reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[0], bus.sda_in};
            scl_prev_q <= scl_cur;
            sda_prev_q <= sda_cur;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  =  scl_cur & ~scl_prev_q;
    assign scl_fall  = ~scl_cur &  scl_prev_q;
    assign bus_start =  scl_cur &  scl_prev_q &  sda_prev_q & ~sda_cur;
    assign bus_stop  =  scl_cur &  scl_prev_q & ~sda_prev_q &  sda_cur;

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rf_we;
    logic [7:0]        regs_q [DEPTH];
    logic [7:0]        rd_byte;

    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rf_we      = 1'b0;

        if (bus_start) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (bus_stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_cur};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        state_d = S_WACK;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = shift_q[0];
                                state_d = S_ADDR_ACK;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = S_IGNORE;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_d = shift_q[ADDR_W-1:0];
                        end else begin
                            rf_we      = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_q;
                            ptr_d      = ptr_q + ADDR_W'(1);
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            shift_d = rd_byte;
                            ptr_d   = ptr_q + ADDR_W'(1);
                            oe_d    = ~rd_byte[7];
                            state_d = S_RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_PTR;
                        end
                    end
                end
                S_WACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RACK;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_cur;
                        cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d = '0;
                        if (ack_q) begin
                            shift_d = rd_byte;
                            ptr_d   = ptr_q + ADDR_W'(1);
                            oe_d    = ~rd_byte[7];
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // An I2C write to an index shadows a same-cycle local write to that index only.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rf_we && ptr_q == ADDR_W'(i))
                    regs_q[i] <= shift_q;
                else if (bus.local_we && bus.local_addr == ADDR_W'(i))
                    regs_q[i] <= bus.local_wdata;
            end
        end
    end

    assign bus.sda_oe       = oe_q;
    assign bus.busy         = busy_q;
    assign bus.reg_wr_valid = wr_valid_q;
    assign bus.reg_wr_addr  = wr_addr_q;
    assign bus.reg_wr_data  = wr_data_q;
    assign bus.local_rdata  = regs_q[bus.local_addr];
endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: an initiator model drives the pads, expected values are
// queued by the stimulus and compared by monitor processes on the opposite clock edge.
module tb_i2c_target_regs;
    localparam int Q = 10;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int LAT = 6;
    localparam logic GLITCH_BUSY = 1'b1;
`else
    localparam int LAT = 3;
    localparam logic GLITCH_BUSY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic scl_drv = 1'b1, sda_drv = 1'b1;
    logic [3:0] laddr = '0;
    logic       lwe = 1'b0;
    logic [7:0] lwdata = '0;

    always #5 clk = ~clk;

    i2c_target_regs_if #(.ADDR_W(4)) bus ();

    assign bus.scl_in      = scl_drv;
    assign bus.sda_in      = sda_drv & ~bus.sda_oe;
    assign bus.local_addr  = laddr;
    assign bus.local_we    = lwe;
    assign bus.local_wdata = lwdata;

    i2c_target_regs #(.TARGET_ADDR(7'h50), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    string      exp_nm_q [$];
    logic [7:0] exp_q    [$];
    logic [7:0] act_q    [$];
    logic [11:0] wr_q    [$];

    logic watch_oe = 1'b0;
    logic oe_seen  = 1'b0;

    always @(negedge clk) if (watch_oe) oe_seen <= oe_seen | bus.sda_oe;

    // Monitor: compares every observation against the next queued expectation.
    initial forever begin
        @(negedge clk);
        while (act_q.size() != 0) begin
            logic [7:0] a, e;
            string nm;
            a = act_q.pop_front();
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got 0x%02h with nothing expected", a);
            end else begin
                e  = exp_q.pop_front();
                nm = exp_nm_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%02h expected 0x%02h", nm, a, e);
                end
            end
        end
    end

    // Monitor: every reg_wr_valid pulse must match the next queued (index, data).
    always @(negedge clk) begin
        if (rst_b && bus.reg_wr_valid) begin
            n_assert++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got (%0d,0x%02h) with nothing expected",
                         bus.reg_wr_addr, bus.reg_wr_data);
            end else begin
                logic [11:0] e;
                e = wr_q.pop_front();
                if ({bus.reg_wr_addr, bus.reg_wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL wr_event: got (%0d,0x%02h) expected (%0d,0x%02h)",
                             bus.reg_wr_addr, bus.reg_wr_data, e[11:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb(input string nm, input logic [7:0] exp_v, input logic [7:0] act_v);
        exp_nm_q.push_back(nm);
        exp_q.push_back(exp_v);
        act_q.push_back(act_v);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wclk(Q);
        scl_drv = 1'b1; wclk(Q);
        sda_drv = 1'b0; wclk(Q);
        scl_drv = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wclk(Q);
        scl_drv = 1'b1; wclk(Q);
        sda_drv = 1'b1; wclk(2 * Q);
    endtask

    // exp_lvl is the SDA level expected in the ACK slot (0 = target ACK).
    task automatic send_byte(input logic [7:0] b, input logic exp_lvl, input string nm,
                             input bit collide);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; wclk(Q);
            scl_drv = 1'b1; wclk(2 * Q);
            scl_drv = 1'b0;
            if (i == 0 && collide) begin
                repeat (LAT - 1) @(posedge clk);
                #1 lwe = 1'b1;
                @(posedge clk);
                #1 lwe = 1'b0;
                wclk(Q - LAT);
            end else begin
                wclk(Q);
            end
        end
        sda_drv = 1'b1; wclk(Q);
        scl_drv = 1'b1; wclk(Q);
        sb(nm, {7'd0, exp_lvl}, {7'd0, bus.sda_in});
        wclk(Q);
        scl_drv = 1'b0; wclk(Q);
    endtask

    task automatic recv_byte(input logic [7:0] exp_b, input logic nack, input string nm);
        logic [7:0] b;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            sda_drv = 1'b1; wclk(Q);
            scl_drv = 1'b1; wclk(Q);
            b[i] = bus.sda_in; wclk(Q);
            scl_drv = 1'b0; wclk(Q);
        end
        sb(nm, exp_b, b);
        sda_drv = nack; wclk(Q);
        scl_drv = 1'b1; wclk(2 * Q);
        scl_drv = 1'b0; wclk(Q);
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp_v, input string nm);
        laddr = a; #1;
        sb(nm, exp_v, bus.local_rdata);
    endtask

    task automatic local_wr(input logic [3:0] a, input logic [7:0] d);
        laddr = a; lwdata = d; lwe = 1'b1;
        wclk(1);
        lwe = 1'b0;
    endtask

    initial begin
        wclk(3);
        sb("rst_sda_oe", 8'h00, {7'd0, bus.sda_oe});
        sb("rst_busy", 8'h00, {7'd0, bus.busy});
        sb("rst_wr_valid", 8'h00, {7'd0, bus.reg_wr_valid});
        sb("rst_wr_addr", 8'h00, {4'd0, bus.reg_wr_addr});
        sb("rst_wr_data", 8'h00, bus.reg_wr_data);
        rd_chk(4'd3, 8'h00, "rst_reg3");
        rst_b = 1'b1;
        wclk(5);

        // Write 0x5A, 0xC3 starting at register 3.
        wr_q.push_back({4'd3, 8'h5A});
        wr_q.push_back({4'd4, 8'hC3});
        i2c_start();
        send_byte(8'hA0, 1'b0, "wr_addr_ack", 1'b0);
        sb("wr_busy", 8'h01, {7'd0, bus.busy});
        send_byte(8'h03, 1'b0, "wr_ptr_ack", 1'b0);
        send_byte(8'h5A, 1'b0, "wr_d0_ack", 1'b0);
        send_byte(8'hC3, 1'b0, "wr_d1_ack", 1'b0);
        i2c_stop();
        rd_chk(4'd3, 8'h5A, "wr_reg3");
        rd_chk(4'd4, 8'hC3, "wr_reg4");
        sb("wr_ptr", 8'h05, {4'd0, dut.ptr_q});

        // Pointer set, repeated START, read two bytes.
        i2c_start();
        send_byte(8'hA0, 1'b0, "rd_addr_ack", 1'b0);
        send_byte(8'h03, 1'b0, "rd_ptr_ack", 1'b0);
        i2c_start();
        send_byte(8'hA1, 1'b0, "rd_addr_r_ack", 1'b0);
        recv_byte(8'h5A, 1'b0, "rd_byte0");
        recv_byte(8'hC3, 1'b1, "rd_byte1");
        sb("rd_release", 8'h00, {7'd0, bus.sda_oe});
        sb("rd_busy_pre_stop", 8'h01, {7'd0, bus.busy});
        i2c_stop();
        sb("rd_busy_post_stop", 8'h00, {7'd0, bus.busy});
        sb("rd_ptr", 8'h05, {4'd0, dut.ptr_q});

        // Address mismatch must leave the bus and registers untouched.
        local_wr(4'd1, 8'h77);
        rd_chk(4'd1, 8'h77, "local_wr_reg1");
        oe_seen  = 1'b0;
        watch_oe = 1'b1;
        i2c_start();
        send_byte(8'hA2, 1'b1, "mm_addr_nack", 1'b0);
        send_byte(8'h01, 1'b1, "mm_b1_nack", 1'b0);
        send_byte(8'hFF, 1'b1, "mm_b2_nack", 1'b0);
        i2c_stop();
        wclk(2);
        watch_oe = 1'b0;
        sb("mm_sda_oe_never", 8'h00, {7'd0, oe_seen});
        rd_chk(4'd1, 8'h77, "mm_reg1");
        rd_chk(4'd3, 8'h5A, "mm_reg3");

        // Pointer wrap 15 -> 0.
        wr_q.push_back({4'd15, 8'h11});
        wr_q.push_back({4'd0, 8'h22});
        i2c_start();
        send_byte(8'hA0, 1'b0, "wrap_addr_ack", 1'b0);
        send_byte(8'h0F, 1'b0, "wrap_ptr_ack", 1'b0);
        send_byte(8'h11, 1'b0, "wrap_d0_ack", 1'b0);
        send_byte(8'h22, 1'b0, "wrap_d1_ack", 1'b0);
        i2c_stop();
        rd_chk(4'd15, 8'h11, "wrap_reg15");
        rd_chk(4'd0, 8'h22, "wrap_reg0");
        sb("wrap_ptr", 8'h01, {4'd0, dut.ptr_q});

        // Upper pointer bits are ignored: 0xF7 selects register 7.
        wr_q.push_back({4'd7, 8'h33});
        i2c_start();
        send_byte(8'hA0, 1'b0, "hi_addr_ack", 1'b0);
        send_byte(8'hF7, 1'b0, "hi_ptr_ack", 1'b0);
        send_byte(8'h33, 1'b0, "hi_d0_ack", 1'b0);
        i2c_stop();
        rd_chk(4'd7, 8'h33, "hi_reg7");

        // Local write to reg2 in the same cycle as the I2C write of 0x44 to reg2.
        wr_q.push_back({4'd2, 8'h44});
        i2c_start();
        send_byte(8'hA0, 1'b0, "col_addr_ack", 1'b0);
        send_byte(8'h02, 1'b0, "col_ptr_ack", 1'b0);
        laddr = 4'd2; lwdata = 8'h99;
        send_byte(8'h44, 1'b0, "col_d0_ack", 1'b1);
        i2c_stop();
        rd_chk(4'd2, 8'h44, "col_reg2");

        // Short SDA low pulse while SCL is high inside a matched transfer.
        i2c_start();
        send_byte(8'hA0, 1'b0, "gl_addr_ack", 1'b0);
        sda_drv = 1'b1; wclk(Q);
        scl_drv = 1'b1; wclk(5);
        sda_drv = 1'b0; wclk(2);
        sda_drv = 1'b1; wclk(13);
        sb("gl_busy", {7'd0, GLITCH_BUSY}, {7'd0, bus.busy});
        sb("gl_sda_oe", 8'h00, {7'd0, bus.sda_oe});
        scl_drv = 1'b0; wclk(Q);
        i2c_stop();

        // Reset while the target drives the 0 MSB of reg3 (0x5A).
        i2c_start();
        send_byte(8'hA0, 1'b0, "rs_addr_ack", 1'b0);
        send_byte(8'h03, 1'b0, "rs_ptr_ack", 1'b0);
        i2c_start();
        send_byte(8'hA1, 1'b0, "rs_addr_r_ack", 1'b0);
        sb("rs_driving_low", 8'h01, {7'd0, bus.sda_oe});
        #3 rst_b = 1'b0;
        #1;
        sb("rs_sda_oe_async", 8'h00, {7'd0, bus.sda_oe});
        for (int i = 0; i < 16; i++) rd_chk(4'(i), 8'h00, "rs_reg_zero");
        sb("rs_ptr", 8'h00, {4'd0, dut.ptr_q});
        wclk(4);
        rst_b = 1'b1;
        wclk(4);
        i2c_stop();

        wclk(20);
        n_assert++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_drain: %0d write events outstanding, expected 0", wr_q.size());
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
